fc_in_neuron_loader: RTL

Write-side companion of the FC control path: fills the PI-banked, true-dual-port input-neuron M9K memories that the FC controller later reads on ports a and b. It accepts a valid/ready stream of input neurons from the previous layer, pairs consecutive neurons, and writes each pair in one cycle (port a even address, port b odd address). Once all INNEURON neurons are written, it pulses fc_start and holds load_done until the next frame.

---
 rtl/fc_in_neuron_loader_pkg.sv | 18 +
 rtl/fc_in_neuron_loader_if.sv | 28 ++
 rtl/fc_in_neuron_loader_addr_map.sv | 23 ++
 rtl/fc_in_neuron_loader.sv | 97 +++++++++
 4 files changed

// File: rtl/fc_in_neuron_loader_pkg.sv
// Shared sizing and state encoding for the FC input-neuron loader.
package fc_in_neuron_loader_pkg;

  localparam int INNEURON               = 64;
  localparam int PI                     = 4;
  localparam int DATA_WIDTH_FC          = 16;
  localparam int FC_INNEURON_ADDR_WIDTH = 4;
  localparam int FC_COUNT_IN_BITWIDTH   = 6;
  localparam int WORDS_PER_BANK         = INNEURON / PI;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } load_state_t;

endpackage

// File: rtl/fc_in_neuron_loader_if.sv
// Neuron stream plus the dual-port write bus into the banked input-neuron memories.
interface fc_in_neuron_loader_if;
  import fc_in_neuron_loader_pkg::*;

  logic [DATA_WIDTH_FC-1:0]          din;
  logic                              din_valid;
  logic                              din_ready;
  logic [PI-1:0]                     in_neuron_wren_a;
  logic [PI-1:0]                     in_neuron_wren_b;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_addr_a;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_addr_b;
  logic [DATA_WIDTH_FC-1:0]          in_neuron_data_a;
  logic [DATA_WIDTH_FC-1:0]          in_neuron_data_b;

  // master is the producer/memory side, slave is the loader
  modport master (
    output din, din_valid,
    input  din_ready, in_neuron_wren_a, in_neuron_wren_b,
           in_neuron_addr_a, in_neuron_addr_b, in_neuron_data_a, in_neuron_data_b
  );

  modport slave (
    input  din, din_valid,
    output din_ready, in_neuron_wren_a, in_neuron_wren_b,
           in_neuron_addr_a, in_neuron_addr_b, in_neuron_data_a, in_neuron_data_b
  );

endinterface

// File: rtl/fc_in_neuron_loader_addr_map.sv
// Maps a frame element index onto its memory bank (one-hot) and in-bank word.
module fc_in_neuron_addr_map
  import fc_in_neuron_loader_pkg::*;
(
  input  logic [FC_COUNT_IN_BITWIDTH-1:0]   elem_cnt,
  output logic [PI-1:0]                     bank_onehot,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] word
);

  localparam logic [FC_COUNT_IN_BITWIDTH-1:0] WPB = FC_COUNT_IN_BITWIDTH'(WORDS_PER_BANK);

  logic [FC_COUNT_IN_BITWIDTH-1:0] bank_idx;

  always_comb begin
    bank_idx    = elem_cnt / WPB;
    word        = FC_INNEURON_ADDR_WIDTH'(elem_cnt % WPB);
    bank_onehot = '0;
    for (int i = 0; i < PI; i++) begin
      bank_onehot[i] = (bank_idx == FC_COUNT_IN_BITWIDTH'(i));
    end
  end

endmodule

// File: rtl/fc_in_neuron_loader.sv
// Pairs incoming neurons and writes each pair through ports a/b of the banked
// input-neuron memories, then pulses fc_start once the frame is complete.
module fc_in_neuron_loader
  import fc_in_neuron_loader_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  fc_in_neuron_loader_if.slave        bus,
  output logic                        load_done,
  output logic                        fc_start
);

  load_state_t state, next_state;

  logic [FC_COUNT_IN_BITWIDTH-1:0]   elem_cnt;
  logic [DATA_WIDTH_FC-1:0]          hold;
  logic [PI-1:0]                     bank_onehot;
  logic [FC_INNEURON_ADDR_WIDTH-1:0] word;
  logic accept, last_beat, clear_cnt, set_done, clear_done;

  fc_in_neuron_addr_map u_addr_map (
    .elem_cnt    (elem_cnt),
    .bank_onehot (bank_onehot),
    .word        (word)
  );

  assign bus.din_ready = (state == LOAD);
  assign accept        = bus.din_valid && (state == LOAD);
  assign last_beat     = (elem_cnt == FC_COUNT_IN_BITWIDTH'(INNEURON - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    clear_cnt  = 1'b0;
    set_done   = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: if (start) begin
        next_state = LOAD;
        clear_cnt  = 1'b1;
      end
      LOAD: if (accept && last_beat) next_state = FINISH;
      FINISH: begin
        next_state = DONE;
        set_done   = 1'b1;
      end
      DONE: if (start) begin
        next_state = LOAD;
        clear_cnt  = 1'b1;
        clear_done = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Even beats park in hold; the odd beat completes the pair and fires a one-cycle write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      elem_cnt             <= '0;
      hold                 <= '0;
      bus.in_neuron_wren_a <= '0;
      bus.in_neuron_wren_b <= '0;
      bus.in_neuron_addr_a <= '0;
      bus.in_neuron_addr_b <= '0;
      bus.in_neuron_data_a <= '0;
      bus.in_neuron_data_b <= '0;
      load_done            <= 1'b0;
      fc_start             <= 1'b0;
    end else begin
      bus.in_neuron_wren_a <= '0;
      bus.in_neuron_wren_b <= '0;
      fc_start             <= set_done;
      if (clear_cnt)   elem_cnt <= '0;
      else if (accept) elem_cnt <= elem_cnt + FC_COUNT_IN_BITWIDTH'(1);
      if (set_done)        load_done <= 1'b1;
      else if (clear_done) load_done <= 1'b0;
      if (accept) begin
        if (!elem_cnt[0]) begin
          hold <= bus.din;
        end else begin
          bus.in_neuron_wren_a <= bank_onehot;
          bus.in_neuron_wren_b <= bank_onehot;
          bus.in_neuron_addr_a <= word - FC_INNEURON_ADDR_WIDTH'(1);
          bus.in_neuron_addr_b <= word;
          bus.in_neuron_data_a <= hold;
          bus.in_neuron_data_b <= bus.din;
        end
      end
    end
  end

endmodule
